// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, baud timing helper, idle line level.
// No logic of its own.
// Optional parity state is present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    // Level the serial line rests at between frames.
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        STATE_IDLE   = 3'd0,
        STATE_START  = 3'd1,
        STATE_DATA   = 3'd2,
        STATE_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , STATE_PARITY = 3'd4
`endif
    } state_t;

    // Number of clk cycles per serial bit (truncating division).
    function automatic int pulse_width(input int systemclock, input int baudrate);
        return systemclock / baudrate;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Word handshake into the UART transmitter: data/valid forward, ready back.
// A word moves on a cycle where tx_data_valid && tx_ready.
// Ready low means the transmitter queue is full; valid is then ignored.
interface uart_tx_if #(
    parameter int ELEMENT_WIDTH = 8
);
    logic [ELEMENT_WIDTH-1:0] tx_data;
    logic                     tx_data_valid;
    logic                     tx_ready;

    modport master (output tx_data, output tx_data_valid, input tx_ready);
    modport slave  (input tx_data, input tx_data_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small word FIFO in front of the UART serialiser; head is read combinationally.
// Latency: a word written on one edge is visible at the head after that edge.
// Backpressure: push is dropped while full (even with a same-cycle pop); pop on empty is ignored.
module uart_tx_fifo #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ELEMENT_WIDTH-1:0] wr_data,
    input  logic                     pop,
    output logic [ELEMENT_WIDTH-1:0] rd_data,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ELEMENT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     do_push;
    logic                     do_pop;

    // Full decision looks only at the current count, so a pop cannot make room for a same-cycle push.
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: queues words and sends start, LSB-first data, [parity], stop frames.
// Latency: start bit falls on tx_line 2 cycles after the accepting edge when idle; frames chain with no gap.
// Backpressure: tx_ready low while the queue is full. Build option UART_TX_PARITY_EN adds an even parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int ELEMENT_WIDTH = 8,
    parameter int BAUDRATE      = 250_000,
    parameter int SYSTEMCLOCK   = 100_000_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     tx_line,
    output logic     tx_busy
);
    localparam int PULSE_WIDTH = pulse_width(SYSTEMCLOCK, BAUDRATE);
    localparam int CNT_W       = $clog2(PULSE_WIDTH) + 1;
    localparam int BIT_W       = $clog2(ELEMENT_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(ELEMENT_WIDTH - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [BIT_W-1:0]         bit_idx;
    logic [BIT_W-1:0]         bit_idx_nxt;
    logic [ELEMENT_WIDTH-1:0] shift;
    logic [ELEMENT_WIDTH-1:0] shift_nxt;
    logic                     line_nxt;
    logic                     busy_nxt;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [ELEMENT_WIDTH-1:0] fifo_head;
`ifdef UART_TX_PARITY_EN
    logic                     parity;
    logic                     parity_nxt;
`endif

    assign bus.tx_ready = !fifo_full;

    uart_tx_fifo #(
        .ELEMENT_WIDTH (ELEMENT_WIDTH),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.tx_data_valid),
        .wr_data (bus.tx_data),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state, counters and line level for the current state; the line flop lags state by one cycle.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        line_nxt    = LINE_IDLE;
        fifo_pop    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt  = parity;
`endif
        case (state)
            STATE_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_head;
                    cnt_nxt   = CNT_RELOAD;
                    state_nxt = STATE_START;
`ifdef UART_TX_PARITY_EN
                    parity_nxt = ^fifo_head;
`endif
                end
            end
            STATE_START: begin
                line_nxt = 1'b0;
                if (cnt == '0) begin
                    cnt_nxt     = CNT_RELOAD;
                    bit_idx_nxt = '0;
                    state_nxt   = STATE_DATA;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            STATE_DATA: begin
                line_nxt = shift[0];
                if (cnt == '0) begin
                    cnt_nxt   = CNT_RELOAD;
                    shift_nxt = shift >> 1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = STATE_PARITY;
`else
                        state_nxt = STATE_STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            STATE_PARITY: begin
                line_nxt = parity;
                if (cnt == '0) begin
                    cnt_nxt   = CNT_RELOAD;
                    state_nxt = STATE_STOP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
`endif
            STATE_STOP: begin
                line_nxt = LINE_IDLE;
                if (cnt == '0) begin
                    // Chain straight into the next start bit when a word is waiting.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_nxt = fifo_head;
                        cnt_nxt   = CNT_RELOAD;
                        state_nxt = STATE_START;
`ifdef UART_TX_PARITY_EN
                        parity_nxt = ^fifo_head;
`endif
                    end else begin
                        state_nxt = STATE_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = STATE_IDLE;
            end
        endcase
        busy_nxt = (state != STATE_IDLE) || !fifo_empty;
    end

    // State, counters, shift register and the registered line/busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= STATE_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_line <= LINE_IDLE;
            tx_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            tx_line <= line_nxt;
            tx_busy <= busy_nxt;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-schedule model checked every cycle, bench-side line decoder,
// and hand-computed literal checks for reset, latency, chaining, full queue and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int EW     = 8;
    localparam int BAUD   = 250_000;
    localparam int SYSCLK = 100_000_000;
    localparam int DEPTH  = 4;
    localparam int PW     = SYSCLK / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS  = EW + 3;
`else
    localparam int NBITS  = EW + 2;
`endif
    localparam int FRAME  = NBITS * PW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_line;
    logic tx_busy;

    uart_tx_if #(.ELEMENT_WIDTH(EW)) bus();

    uart_tx #(
        .ELEMENT_WIDTH (EW),
        .BAUDRATE      (BAUD),
        .SYSTEMCLOCK   (SYSCLK),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .tx_line (tx_line),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: each accepted word gets a line start time L; frames occupy [L, L+FRAME).
    typedef struct {
        logic [EW-1:0] w;
        int            a;
        int            l;
    } frm_t;
    frm_t frames[$];
    int   last_l = -1000000;

    function automatic logic m_ready(input int n);
        int c = 0;
        foreach (frames[i]) if (frames[i].a <= n && n < frames[i].l - 1) c++;
        return (c < DEPTH);
    endfunction

    function automatic logic m_busy(input int n);
        foreach (frames[i]) if (n >= frames[i].l - 1 && n < frames[i].l + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_line(input int n);
        int k;
        foreach (frames[i]) begin
            if (n >= frames[i].l && n < frames[i].l + FRAME) begin
                k = (n - frames[i].l) / PW;
                if (k == 0) return 1'b0;
                if (k <= EW) return frames[i].w[k-1];
`ifdef UART_TX_PARITY_EN
                if (k == EW + 1) return ^frames[i].w;
`endif
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        logic r;
        int   l;
        if (rst) begin
            frames.delete();
            last_l = -1000000;
            cyc++;
        end else begin
            r = m_ready(cyc);
            cyc++;
            if (bus.tx_data_valid === 1'b1 && r) begin
                l = (cyc + 2 > last_l + FRAME) ? cyc + 2 : last_l + FRAME;
                frames.push_back('{bus.tx_data, cyc, l});
                last_l = l;
            end
            while (frames.size() > 0 && frames[0].l + FRAME + 4 < cyc) void'(frames.pop_front());
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) chk("line/busy/ready", {29'd0, tx_line, tx_busy, bus.tx_ready},
                        {29'd0, m_line(cyc), m_busy(cyc), m_ready(cyc)});
    end

    // Bench-side serial decoder sampling mid-bit.
    bit            rx_en   = 1'b1;
    int            rx_st   = 0;
    int            rx_t0   = 0;
    int            rx_k    = 0;
    logic          rx_prev = 1'b1;
    logic [EW-1:0] rx_w    = '0;
    logic [EW-1:0] rx_q[$];
    always @(negedge clk) begin
        if (!rx_en || !chk_en) begin
            rx_st   = 0;
            rx_prev = 1'b1;
        end else begin
            if (rx_st == 0) begin
                if (rx_prev === 1'b1 && tx_line === 1'b0) begin
                    rx_st = 1;
                    rx_t0 = cyc;
                end
            end else if ((cyc - rx_t0) % PW == PW / 2) begin
                rx_k = (cyc - rx_t0) / PW;
                if (rx_k == 0) chk("rx_start_bit", tx_line, 1'b0);
                else if (rx_k <= EW) rx_w[rx_k-1] = tx_line;
`ifdef UART_TX_PARITY_EN
                else if (rx_k == EW + 1) chk("rx_parity", tx_line, ^rx_w);
`endif
                if (rx_k == NBITS - 1) begin
                    chk("rx_stop_bit", tx_line, 1'b1);
                    rx_q.push_back(rx_w);
                    rx_st = 0;
                end
            end
            rx_prev = tx_line;
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; holds valid until accepted and returns at posedge+1 with valid still high.
    task automatic send(input logic [EW-1:0] w, output int a);
        logic r;
        a = -1;
        bus.tx_data       = w;
        bus.tx_data_valid = 1'b1;
        for (int i = 0; i < 2 * FRAME && a < 0; i++) begin
            @(negedge clk);
            r = bus.tx_ready;
            @(posedge clk);
            #1;
            if (r === 1'b1) a = cyc;
        end
        if (a < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: word %0h never accepted (cycle %0d)", w, cyc);
        end
    endtask

    initial begin
        int a, a2, L, bad, acc;
        int a5_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        logic [EW-1:0] sent[5];

        bus.tx_data       = '0;
        bus.tx_data_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state and idle hold.
        chk("reset_line", tx_line, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);
        chk("reset_ready", bus.tx_ready, 1'b1);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_line !== 1'b1 || tx_busy !== 1'b0 || bus.tx_ready !== 1'b1) bad++;
        end
        chk("idle_hold_violations", bad, 0);

        // Single frame 0xA5.
        sync();
        send(8'hA5, a);
        bus.tx_data_valid = 1'b0;
        L = a + 2;
        wait_cyc(a + 1);
        chk("a5_line_before_start", tx_line, 1'b1);
        wait_cyc(L);
        chk("a5_start_fall", tx_line, 1'b0);
        wait_cyc(L + PW - 1);
        chk("a5_start_end", tx_line, 1'b0);
        for (int k = 0; k < 8; k++) begin
            wait_cyc(L + (k + 1) * PW + PW / 2);
            chk($sformatf("a5_bit%0d", k), tx_line, a5_bits[k]);
        end
        wait_cyc(L + (NBITS - 1) * PW + PW / 2);
        chk("a5_stop", tx_line, 1'b1);
        wait_cyc(L + FRAME - 1);
        chk("a5_busy_last", tx_busy, 1'b1);
        wait_cyc(L + FRAME);
        chk("a5_busy_drop", tx_busy, 1'b0);
        chk("a5_rx_count", rx_q.size(), 1);
        if (rx_q.size() == 1) chk("a5_rx_word", rx_q[0], 8'hA5);
        rx_q.delete();

        // Back-to-back 0x00 then 0xFF.
        sync();
        send(8'h00, a);
        send(8'hFF, a2);
        bus.tx_data_valid = 1'b0;
        chk("b2b_consecutive", a2 - a, 1);
        L = a + 2;
        wait_cyc(L);
        chk("b2b_first_start", tx_line, 1'b0);
        wait_cyc(L + FRAME - 1);
        chk("b2b_first_stop", tx_line, 1'b1);
        wait_cyc(L + FRAME);
        chk("b2b_second_start", tx_line, 1'b0);
        wait_cyc(L + FRAME + PW);
        chk("b2b_second_bit0", tx_line, 1'b1);
        wait_cyc(L + 2 * FRAME - 1);
        chk("b2b_busy_last", tx_busy, 1'b1);
        wait_cyc(L + 2 * FRAME);
        chk("b2b_busy_drop", tx_busy, 1'b0);
        chk("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("b2b_rx0", rx_q[0], 8'h00);
            chk("b2b_rx1", rx_q[1], 8'hFF);
        end
        rx_q.delete();

        // Full queue: valid for 8 cycles with 1..8.
        sync();
        acc = 0;
        a   = 0;
        for (int i = 1; i <= 8; i++) begin
            bus.tx_data       = EW'(i);
            bus.tx_data_valid = 1'b1;
            @(negedge clk);
            if (bus.tx_ready === 1'b1) acc++;
            @(posedge clk);
            #1;
            if (i == 1) a = cyc;
        end
        bus.tx_data_valid = 1'b0;
        chk("full_accepted", acc, 5);
        chk("full_ready_low", bus.tx_ready, 1'b0);
        L = a + 2;
        wait_cyc(L + FRAME - 2);
        chk("full_ready_before_pop", bus.tx_ready, 1'b0);
        wait_cyc(L + FRAME - 1);
        chk("full_ready_after_pop", bus.tx_ready, 1'b1);
        wait_cyc(L + 5 * FRAME);
        chk("full_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < rx_q.size()) chk($sformatf("full_rx%0d", i), rx_q[i], i + 1);
        rx_q.delete();

        // Reset during the third data bit of 0x3C with two words queued.
        rx_en = 1'b0;
        sync();
        send(8'h3C, a);
        send(8'h11, a2);
        send(8'h22, a2);
        bus.tx_data_valid = 1'b0;
        L = a + 2;
        wait_cyc(L + 3 * PW + 200);
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        chk("rst_line", tx_line, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_ready", bus.tx_ready, 1'b1);
        bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (tx_line !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("rst_nothing_sent", bad, 0);
        rx_en = 1'b1;

        // Loopback through the decoder with random words.
        sync();
        for (int i = 0; i < 5; i++) begin
            sent[i] = EW'($urandom_range(0, 255));
            send(sent[i], a);
        end
        bus.tx_data_valid = 1'b0;
        for (int i = 0; i < 6 * FRAME && rx_q.size() < 5; i++) @(negedge clk);
        chk("lb_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < rx_q.size()) chk($sformatf("lb_rx%0d", i), rx_q[i], sent[i]);
        wait_cyc(cyc + PW);
        rx_q.delete();

`ifdef UART_TX_PARITY_EN
        // Parity frame for 0x07: odd number of ones, parity bit 1, 4400-cycle frame.
        sync();
        send(8'h07, a);
        bus.tx_data_valid = 1'b0;
        L = a + 2;
        wait_cyc(L + 9 * PW + PW / 2);
        chk("par_bit_07", tx_line, 1'b1);
        wait_cyc(L + 4399);
        chk("par_busy_last", tx_busy, 1'b1);
        wait_cyc(L + 4400);
        chk("par_busy_drop", tx_busy, 1'b0);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
